// File: rtl/subkey_arb_pkg.sv
// subkey_arb_pkg: FSM state encoding, default subkey width and a saturating increment shared by subkey_arbiter
package subkey_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        FETCH   = 3'd2,
        PRESENT = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam int SUBKEY_W_DEF = 24;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/subkey_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder; the first requester at or after ptr (wrapping) wins
module rr_pick #(
    parameter int N_GEN = 16,
    parameter int SRC_W = (N_GEN > 1) ? $clog2(N_GEN) : 1
) (
    input  logic [N_GEN-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [SRC_W:0] pos;

    // scan from the slot farthest from ptr back towards ptr so the nearest requester is the last writer
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        pos       = '0;
        for (int k = N_GEN - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (SRC_W + 1)'(k);
            if (pos >= (SRC_W + 1)'(N_GEN)) pos = pos - (SRC_W + 1)'(N_GEN);
            if (req[pos[SRC_W-1:0]]) begin
                gnt_idx   = pos[SRC_W-1:0];
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/subkey_arbiter.sv
// subkey_arbiter: drains N_GEN GenSubkey FIFOs round-robin onto a valid/ready port; optional SUBKEY_ARB_STATS_EN adds STALL_CYCLES
module subkey_arbiter
    import subkey_arb_pkg::*;
#(
    parameter  int N_GEN    = 16,
    parameter  int SUBKEY_W = SUBKEY_W_DEF,
    localparam int SRC_W    = (N_GEN > 1) ? $clog2(N_GEN) : 1
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic                      START,
    input  logic [N_GEN-1:0]          GEN_DONE,
    input  logic [N_GEN-1:0]          GEN_EMPTY,
    input  logic [N_GEN*SUBKEY_W-1:0] GEN_RDDATA,
    output logic [N_GEN-1:0]          GEN_RDEN,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [SUBKEY_W-1:0]       OUT_SUBKEY,
    output logic [SRC_W-1:0]          OUT_SRC,
    output logic                      ALL_DONE,
    output logic [31:0]               COUNT
`ifdef SUBKEY_ARB_STATS_EN
    ,
    output logic [31:0]               STALL_CYCLES
`endif
);

    state_t           state, state_nx;
    logic [SRC_W-1:0] ptr, sel, gnt_idx;
    logic             gnt_valid, done_seen, start_ok;
    logic [31:0]      count_q;

    assign COUNT    = count_q;
    assign start_ok = START && (state == IDLE || state == FINISH);

    rr_pick #(.N_GEN(N_GEN), .SRC_W(SRC_W)) u_pick (
        .req       (~GEN_EMPTY),
        .ptr       (ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // read strobe lives only in ARB and only for the granted, non-empty FIFO
    always_comb GEN_RDEN = (state == ARB && gnt_valid) ? (N_GEN'(1) << gnt_idx) : '0;

    // state register
    always_ff @(posedge CLK) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nx;
    end

    // next-state: FINISH needs two consecutive all-done/all-empty ARB cycles to absorb empty-flag lag
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FINISH: state_nx = start_ok ? ARB : state;
            ARB:          state_nx = gnt_valid ? FETCH : ((&GEN_DONE && done_seen) ? FINISH : ARB);
            FETCH:        state_nx = PRESENT;
            PRESENT:      state_nx = OUT_READY ? ARB : PRESENT;
            default:      state_nx = IDLE;
        endcase
    end

    // datapath: grant capture, output register, round-robin pointer, completion and delivery count
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            ptr        <= '0;
            sel        <= '0;
            done_seen  <= 1'b0;
            OUT_VALID  <= 1'b0;
            OUT_SUBKEY <= '0;
            OUT_SRC    <= '0;
            ALL_DONE   <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (START) begin
                        count_q   <= '0;
                        ALL_DONE  <= 1'b0;
                        ptr       <= '0;
                        done_seen <= 1'b0;
                    end
                end
                ARB: begin
                    if (gnt_valid) begin
                        sel       <= gnt_idx;
                        done_seen <= 1'b0;
                    end else if (&GEN_DONE) begin
                        done_seen <= 1'b1;
                        if (done_seen) ALL_DONE <= 1'b1;
                    end else begin
                        done_seen <= 1'b0;
                    end
                end
                FETCH: begin
                    OUT_SUBKEY <= GEN_RDDATA[sel*SUBKEY_W +: SUBKEY_W];
                    OUT_SRC    <= sel;
                    OUT_VALID  <= 1'b1;
                end
                PRESENT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        count_q   <= sat_inc(count_q);
                        ptr       <= (sel == SRC_W'(N_GEN - 1)) ? '0 : sel + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUBKEY_ARB_STATS_EN
    // back-pressure counter: cycles a subkey waited on the downstream stage
    always_ff @(posedge CLK) begin
        if (!RESETn || start_ok)         STALL_CYCLES <= '0;
        else if (OUT_VALID && !OUT_READY) STALL_CYCLES <= sat_inc(STALL_CYCLES);
    end
`endif

endmodule
